// File: rtl/rk_crt_fetch.sv
// CRT row fetcher: double-buffers one character row of screen RAM per display row
// and streams characters to the video stage on each character-clock enable.
module rk_crt_fetch #(
  parameter int unsigned CHARS   = 78,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned LPR     = 10,
  parameter logic [15:0] BASE    = 16'h76D0,
  parameter int unsigned UL_LINE = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cce,
  input  logic        hr_wg75,
  input  logic        vr_wg75,
  input  logic [6:0]  cur_x,
  input  logic [4:0]  cur_y,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [6:0]  ichar,
  output logic [3:0]  line,
  output logic        vsp,
  output logic        lten,
  output logic        rvv,
  output logic        underrun
);

  localparam logic [6:0]  CHARS_W   = 7'(CHARS);
  localparam logic [6:0]  LAST_IDX  = 7'(CHARS - 1);
  localparam logic [4:0]  ROWS_W    = 5'(ROWS);
  localparam logic [5:0]  ROWS_6    = 6'(ROWS);
  localparam logic [3:0]  LAST_LINE = 4'(LPR - 1);
  localparam logic [3:0]  UL_W      = 4'(UL_LINE);
  localparam logic [15:0] ROW_STEP  = 16'(CHARS);
  localparam logic [15:0] ROW1_BASE = BASE + ROW_STEP;
  localparam logic [15:0] ROW2_BASE = ROW1_BASE + ROW_STEP;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fstate_t;
  fstate_t state_q, state_d;

  logic        hr_q, vr_q;
  logic        hs_fall, vs_fall, vs_rise;
  logic [4:0]  row;
  logic [3:0]  ln;
  logic [6:0]  col;
  logic [3:0]  fc;
  logic        disp_sel, fill_valid, disp_valid;
  logic [15:0] next_base, pend_addr, go_addr;
  logic [6:0]  idx, rd_idx;
  logic [7:0]  rd_byte;
  logic        vis, swap, fetch_go;
  logic        wr, adv, load_go, load_pend, save_pend, fill_done;
  logic [7:0]  rowbuf0 [CHARS];
  logic [7:0]  rowbuf1 [CHARS];

  assign hs_fall = hr_q & ~hr_wg75;
  assign vs_fall = vr_q & ~vr_wg75;
  assign vs_rise = ~vr_q & vr_wg75;
  assign mem_req = (state_q != IDLE);

  // Sync-event decode: which fetch (if any) starts this cycle and whether buffers swap.
  always_comb begin
    swap     = 1'b0;
    fetch_go = 1'b0;
    go_addr  = next_base;
    if (vs_fall) begin
      fetch_go = 1'b1;
      go_addr  = BASE;
    end else if (vs_rise) begin
      swap     = 1'b1;
      fetch_go = 1'b1;
      go_addr  = ROW1_BASE;
    end else if (hs_fall && ln == LAST_LINE) begin
      swap     = 1'b1;
      fetch_go = (({1'b0, row} + 6'd2) < ROWS_6);
    end
  end

  // A start that arrives mid-beat is parked in pend_addr; DRAIN finishes the
  // outstanding beat (data discarded) so mem_req never drops before its ack.
  always_comb begin
    state_d   = state_q;
    wr        = 1'b0;
    adv       = 1'b0;
    load_go   = 1'b0;
    load_pend = 1'b0;
    save_pend = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_go) begin
          state_d = REQ;
          load_go = 1'b1;
        end
      end
      REQ: begin
        wr = mem_ack;
        if (fetch_go) begin
          if (mem_ack) begin
            load_go = 1'b1;
          end else begin
            state_d   = DRAIN;
            save_pend = 1'b1;
          end
        end else if (mem_ack) begin
          if (idx == LAST_IDX) begin
            state_d   = IDLE;
            fill_done = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      DRAIN: begin
        save_pend = fetch_go;
        if (mem_ack) begin
          state_d   = REQ;
          load_go   = fetch_go;
          load_pend = ~fetch_go;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_addr  <= '0;
      idx       <= '0;
      pend_addr <= '0;
    end else begin
      state_q <= state_d;
      if (load_go) begin
        mem_addr <= go_addr;
        idx      <= '0;
      end else if (load_pend) begin
        mem_addr <= pend_addr;
        idx      <= '0;
      end else if (adv) begin
        mem_addr <= mem_addr + 16'd1;
        idx      <= idx + 7'd1;
      end
      if (save_pend) pend_addr <= go_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      if (disp_sel) rowbuf0[idx] <= mem_data;
      else          rowbuf1[idx] <= mem_data;
    end
  end

  assign rd_idx  = (col < CHARS_W) ? col : '0;
  assign rd_byte = disp_sel ? rowbuf1[rd_idx] : rowbuf0[rd_idx];
  assign vis     = (col < CHARS_W) && (row < ROWS_W) && disp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr_q       <= 1'b1;
      vr_q       <= 1'b1;
      row        <= '0;
      ln         <= '0;
      col        <= '0;
      fc         <= '0;
      disp_sel   <= 1'b0;
      fill_valid <= 1'b0;
      disp_valid <= 1'b0;
      underrun   <= 1'b0;
      next_base  <= ROW1_BASE;
      ichar      <= '0;
      line       <= '0;
      vsp        <= 1'b1;
      lten       <= 1'b0;
      rvv        <= 1'b0;
    end else begin
      hr_q <= hr_wg75;
      vr_q <= vr_wg75;
      if (fill_done) fill_valid <= 1'b1;
      if (swap) begin
        disp_sel   <= ~disp_sel;
        disp_valid <= fill_valid && (state_q == IDLE);
        fill_valid <= 1'b0;
        if (state_q != IDLE) underrun <= 1'b1;
      end
      if (vs_fall) begin
        fill_valid <= 1'b0;
        fc         <= fc + 4'd1;
        next_base  <= ROW1_BASE;
      end else if (vs_rise) begin
        row       <= '0;
        ln        <= '0;
        col       <= '0;
        next_base <= ROW2_BASE;
      end else if (hs_fall) begin
        col <= '0;
        if (ln == LAST_LINE) begin
          ln <= '0;
          if (row < ROWS_W) row <= row + 5'd1;
          if (fetch_go) next_base <= next_base + ROW_STEP;
        end else begin
          ln <= ln + 4'd1;
        end
      end else if (cce) begin
        ichar <= vis ? rd_byte[6:0] : '0;
        rvv   <= vis & rd_byte[7];
        vsp   <= ~vis;
        line  <= ln;
        lten  <= vis && (row == cur_y) && (col == cur_x) && (ln == UL_W) && !fc[3];
        if (col < CHARS_W) col <= col + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_rk_crt_fetch.sv
// Directed bench for rk_crt_fetch: a queue scoreboard checks the character stream,
// a memory model answers reads and watches request/address stability.
module tb_rk_crt_fetch;

  logic        clk, reset, cce, hr_wg75, vr_wg75;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [6:0]  ichar;
  logic [3:0]  line;
  logic        vsp, lten, rvv, underrun;

  rk_crt_fetch dut (
    .clk(clk), .reset(reset), .cce(cce), .hr_wg75(hr_wg75), .vr_wg75(vr_wg75),
    .cur_x(cur_x), .cur_y(cur_y), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .ichar(ichar), .line(line),
    .vsp(vsp), .lten(lten), .rvv(rvv), .underrun(underrun)
  );

  typedef struct packed {
    logic [6:0] ichar;
    logic       rvv;
    logic       vsp;
    logic [3:0] line;
    logic       lten;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          acks   = 0;
  int          ack_dly = 1;
  int          fc_model = 0;
  logic        c1_mode = 1'b0;
  logic        cce_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hsync();
    hr_wg75 = 1'b0; tick();
    hr_wg75 = 1'b1; tick();
  endtask

  task automatic do_cce();
    cce = 1'b1; tick();
    cce = 1'b0;
  endtask

  task automatic wait_fetch(input string name);
    for (int n = 0; n < 300; n++) begin
      if (!mem_req) break;
      tick();
    end
    chk(name, mem_req, 1'b0);
  endtask

  task automatic frame();
    vr_wg75 = 1'b0; tick();
    fc_model++;
    wait_fetch("frame_row0_fetch");
    vr_wg75 = 1'b1; tick();
    wait_fetch("frame_row1_fetch");
  endtask

  // Row 0 byte at column c is the low address byte (BASE low byte D0 + c).
  task automatic push_data(input int c, input logic [3:0] ln, input logic c1);
    exp_t       e;
    logic [7:0] b;
    b = (c1 && c == 0) ? 8'hC1 : 8'(8'hD0 + c);
    if (c >= 78) begin
      e = '{ichar: 7'h00, rvv: 1'b0, vsp: 1'b1, line: ln, lten: 1'b0};
    end else begin
      e = '{ichar: b[6:0], rvv: b[7], vsp: 1'b0, line: ln,
            lten: (c == 2 && ln == 4'd7 && fc_model < 8)};
    end
    exp_q.push_back(e);
  endtask

  task automatic push_blank(input logic [3:0] ln);
    exp_q.push_back('{ichar: 7'h00, rvv: 1'b0, vsp: 1'b1, line: ln, lten: 1'b0});
  endtask

  always @(posedge clk) cce_q <= cce & ~reset;

  // Character-stream monitor.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (cce_q) begin
        a = '{ichar: ichar, rvv: rvv, vsp: vsp, line: line, lten: lten};
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: got ichar=%h rvv=%b vsp=%b line=%0d lten=%b, expected no output",
                   a.ichar, a.rvv, a.vsp, a.line, a.lten);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL stream: got ichar=%h rvv=%b vsp=%b line=%0d lten=%b, expected ichar=%h rvv=%b vsp=%b line=%0d lten=%b",
                     a.ichar, a.rvv, a.vsp, a.line, a.lten, e.ichar, e.rvv, e.vsp, e.line, e.lten);
          end
        end
      end
    end
  end

  // Memory model: acks after ack_dly cycles of request; checks request hold.
  initial begin
    int          wait_cnt;
    logic        prev_req, prev_ack;
    logic [15:0] prev_addr, ea;
    mem_ack = 1'b0; mem_data = '0;
    wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0; wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
      end else begin
        if (prev_req && !prev_ack) begin
          checks++;
          if (!mem_req || mem_addr !== prev_addr) begin
            fails++;
            $display("FAIL req_hold: got mem_req=%b addr=%h, expected mem_req=1 addr=%h",
                     mem_req, mem_addr, prev_addr);
          end
        end
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wait_cnt >= ack_dly - 1) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            mem_data = (c1_mode && mem_addr == 16'h76D0) ? 8'hC1 : mem_addr[7:0];
            acks++;
            if (addr_q.size() > 0) begin
              ea = addr_q.pop_front();
              checks++;
              if (mem_addr !== ea) begin
                fails++;
                $display("FAIL fetch_addr: got %h, expected %h", mem_addr, ea);
              end
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
        prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      end
    end
  end

  initial begin
    reset = 1'b1; cce = 1'b0; hr_wg75 = 1'b1; vr_wg75 = 1'b1;
    cur_x = 7'd2; cur_y = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ichar", ichar, 7'h00);
    chk("rst_line", line, 4'd0);
    chk("rst_vsp", vsp, 1'b1);
    chk("rst_lten", lten, 1'b0);
    chk("rst_rvv", rvv, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    reset = 1'b0; tick();

    // Row 0 fetch on vs_fall with single-cycle acks.
    for (int i = 0; i < 78; i++) addr_q.push_back(16'h76D0 + 16'(i));
    acks = 0;
    vr_wg75 = 1'b0; tick();
    fc_model++;
    wait_fetch("row0_fetch");
    chk("row0_acks", acks, 78);
    chk("row0_addr_all_seen", addr_q.size(), 0);

    vr_wg75 = 1'b1; tick();
    chk("row1_req", mem_req, 1'b1);
    chk("row1_addr", mem_addr, 16'h771E);
    for (int c = 0; c < 3; c++) begin
      push_data(c, 4'd0, 1'b0);
      do_cce();
    end

    // Underline line: cursor at column 2, then past end of row.
    repeat (7) hsync();
    for (int c = 0; c < 80; c++) begin
      push_data(c, 4'd7, 1'b0);
      do_cce();
    end

    c1_mode = 1'b1;
    frame();
    c1_mode = 1'b0;
    push_data(0, 4'd0, 1'b1);
    do_cce();

    // Advance frame counter to 8: cursor blinked off.
    repeat (6) frame();
    repeat (7) hsync();
    for (int c = 0; c < 3; c++) begin
      push_data(c, 4'd7, 1'b0);
      do_cce();
    end

    // Underrun: slow memory, short rows.
    frame();
    ack_dly = 40;
    repeat (10) hsync();
    chk("no_underrun_yet", underrun, 1'b0);
    chk("row2_fetching", mem_req, 1'b1);
    repeat (10) hsync();
    chk("underrun_set", underrun, 1'b1);
    for (int k = 0; k < 5; k++) begin
      push_blank(4'd0);
      do_cce();
    end
    repeat (50) tick();
    chk("refetch_active", mem_req, 1'b1);

    // Reset mid-request.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    chk("midrst_vsp", vsp, 1'b1);
    chk("midrst_underrun", underrun, 1'b0);
    chk("midrst_ichar", ichar, 7'h00);
    chk("midrst_line", line, 4'd0);
    chk("midrst_lten", lten, 1'b0);
    chk("midrst_rvv", rvv, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", mem_req, 1'b0);
    chk("post_rst_underrun", underrun, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rk_crt_fetch.md
RK_CRT_FETCH -- requirements
Module: rk_crt_fetch

Interface
REQ-001 SHALL have parameter CHARS, default 78: characters per row.
REQ-002 SHALL have parameter ROWS, default 30: character rows per frame.
REQ-003 SHALL have parameter LPR, default 10: scan lines per character row.
REQ-004 SHALL have parameter BASE, default 16'h76D0: screen RAM base address.
REQ-005 SHALL have parameter UL_LINE, default 7: cursor underline scan line.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port cce, input, 1 bit: one-cycle character-clock enable from the video stage.
REQ-009 SHALL have port hr_wg75, input, 1 bit: horizontal sync, active-low.
REQ-010 SHALL have port vr_wg75, input, 1 bit: vertical sync, active-low.
REQ-011 SHALL have port cur_x, input, 7 bits: cursor column.
REQ-012 SHALL have port cur_y, input, 5 bits: cursor row.
REQ-013 SHALL have port mem_req, output, 1 bit: read request.
REQ-014 SHALL have port mem_addr, output, 16 bits: read address.
REQ-015 SHALL have port mem_ack, input, 1 bit: read completion; mem_data valid in the same cycle.
REQ-016 SHALL have port mem_data, input, 8 bits: read data.
REQ-017 SHALL have ports ichar (output, 7 bits), line (output, 4 bits), vsp (output, 1 bit), lten (output, 1 bit) and rvv (output, 1 bit): character stream to the video stage.
REQ-018 SHALL have port underrun, output, 1 bit: sticky fetch-late flag.

Function
REQ-019 SHALL detect sync edges on a registered copy of each sync; hs_fall = hr_wg75 1->0, vs_fall and vs_rise likewise for vr_wg75.
REQ-020 SHALL hold two row buffers of CHARS bytes, selected by disp_sel (display) and fill_sel = ~disp_sel (fetch).
REQ-021 SHALL define the fetch FSM states IDLE, REQ and DRAIN.
- IDLE -> REQ on a fetch start.
- REQ: mem_req=1 and mem_addr stable until mem_ack; on ack write mem_data to buf[fill_sel][idx] and increment idx/addr; after the ack for idx=CHARS-1, go IDLE and set fill_valid=1.
- REQ may keep mem_req high across consecutive beats.
REQ-022 SHALL start a fetch with address BASE+r*CHARS and idx=0, computed incrementally without a multiplier in the per-beat path.
REQ-023 SHALL, on vs_fall, clear fill_valid, start the fetch of row 0 and increment the 4-bit frame counter fc.
REQ-024 SHALL, on vs_rise, set row=0, line=0, col=0, perform a swap and start the fetch of row 1.
- Swap: disp_sel<=fill_sel; disp_valid<=fill_valid; fill_valid<=0.
REQ-025 SHALL, on hs_fall with line<LPR-1, increment line and clear col.
REQ-026 SHALL, on hs_fall with line=LPR-1, set line=0, clear col, increment row, swap, and start the fetch of row+2 only if row+2<ROWS.
REQ-027 SHALL treat a swap while the FSM is not IDLE as an underrun: set underrun=1 and disp_valid=0.
- The in-flight beat still completes (DRAIN waits for mem_ack, then drops mem_req).
- The new fetch then starts; mem_req SHALL never drop before ack.
REQ-028 SHALL give hs_fall/vs events priority over cce in the same cycle; col is cleared and cce ignored.
REQ-029 SHALL, on cce, update outputs one clk later and hold them until the next update.
- If col<CHARS, row<ROWS and disp_valid: ichar=b[6:0], rvv=b[7], vsp=0 (b = buf[disp_sel][col]); else ichar=0, rvv=0, vsp=1.
- line = current line.
- lten=1 only when row=cur_y, col=cur_x, line=UL_LINE, fc[3]=0 and vsp=0.
- col increments, saturating at CHARS.
REQ-030 SHALL saturate row at ROWS; rows >= ROWS output vsp=1.

Reset
REQ-031 SHALL, on reset asserted, asynchronously force: mem_req=0, mem_addr=0, ichar=0, line=0, vsp=1, lten=0, rvv=0, underrun=0, FSM=IDLE, row=col=0, fc=0, disp_sel=0, fill_valid=disp_valid=0.
REQ-032 SHALL, on reset asserted mid-fetch, abandon the transaction immediately; underrun clears only on reset.

Verification
REQ-033 SHALL cover: reset, then vs_fall with 1-cycle-ack memory returning addr[7:0] -> mem_addr runs 16'h76D0..16'h771D, 78 acks, fill_valid=1.
REQ-034 SHALL cover: vs_rise then 3 cce -> ichar = 7'h50,7'h51,7'h52 (row 0 data), vsp=0, line=0; the fetch of row 1 starts at 16'h771E.
REQ-035 SHALL cover: mem_data=8'hC1 at col 0 -> ichar=7'h41, rvv=1; col 78 and beyond -> vsp=1.
REQ-036 SHALL cover: cur_x=2, cur_y=0, fc=0, line 7 -> lten=1 at col 2 only; after 8 vs_fall (fc[3]=1) -> lten=0.
REQ-037 SHALL cover: ack delay 40 cycles with short row time -> underrun=1, the next row shows vsp=1 for every cce, no mem_req drop before ack.
REQ-038 SHALL cover: reset pulse mid-REQ -> mem_req=0 within the same cycle, vsp=1, all state at reset values.
